fd_pipeline_register: RTL and testbench

FD_PIPELINE_REGISTER -- requirements
Module: fd_pipeline_register

---
 rtl/fd_pipeline_register_pkg.sv | 24 ++
 rtl/fd_pipeline_register_slice.sv | 27 ++
 rtl/fd_pipeline_register.sv | 65 ++++++
 tb/tb_fd_pipeline_register.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fd_pipeline_register_pkg.sv
// Shared types and constants for the fetch/decode pipeline register.
// Holds the default field width, the bubble encoding and the stage bundle layout.
package fd_pipeline_register_pkg;

  localparam int FD_XLEN = 32;
  localparam logic [FD_XLEN-1:0] FD_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [FD_XLEN-1:0] pc;
    logic [FD_XLEN-1:0] instruction;
    logic               valid;
  } fd_bundle_t;

  // Bubble keeps the PC so a redirected slot still carries a meaningful address.
  function automatic fd_bundle_t fd_bubble(input logic [FD_XLEN-1:0] pc,
                                           input logic [FD_XLEN-1:0] nop);
    fd_bundle_t b;
    b.pc          = pc;
    b.instruction = nop;
    b.valid       = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fd_pipeline_register_slice.sv
// Generic register slice: async reset value, load enable, synchronous clear-to-value.
// Latency 1 clock; ld_en=0 holds contents, clr overrides hold.
// Backpressure: caller deasserts ld_en to stall; no internal buffering.
module pipe_reg_slice #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_en,
  input  logic         clr,
  input  logic [W-1:0] clr_val,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= clr_val;
    end else if (ld_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fd_pipeline_register.sv
// Fetch->decode pipeline register; flush port compiled in only with FD_FLUSH_EN.
// Latency 1 clock, all outputs straight from flops.
// Backpressure: stall holds contents; flush (when present) wins over stall and inserts a bubble.
module fd_pipeline_register
  import fd_pipeline_register_pkg::*;
#(
  // Must match FD_XLEN: the stage bundle layout is fixed by the package.
  parameter int              XLEN      = FD_XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = FD_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_value_next,
  input  logic [XLEN-1:0] next_instruction,
  input  logic            valid_next,
  input  logic            stall,
`ifdef FD_FLUSH_EN
  input  logic            flush,
`endif
  output logic [XLEN-1:0] pc_value,
  output logic [XLEN-1:0] instruction,
  output logic            valid
);

  localparam int BW = $bits(fd_bundle_t);
  localparam logic [BW-1:0] RST_BUNDLE = {{XLEN{1'b0}}, NOP_INSTR, 1'b0};

  fd_bundle_t d_bundle;
  fd_bundle_t clr_bundle;
  fd_bundle_t q_bundle;
  logic       clr;

  always_comb begin
    d_bundle             = '0;
    d_bundle.pc          = pc_value_next;
    d_bundle.instruction = next_instruction;
    d_bundle.valid       = valid_next;
  end

`ifdef FD_FLUSH_EN
  assign clr        = flush;
  assign clr_bundle = fd_bubble(pc_value_next, NOP_INSTR);
`else
  assign clr        = 1'b0;
  assign clr_bundle = RST_BUNDLE;
`endif

  pipe_reg_slice #(
    .W       (BW),
    .RST_VAL (RST_BUNDLE)
  ) u_slice (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_en   (~stall),
    .clr     (clr),
    .clr_val (clr_bundle),
    .d       (d_bundle),
    .q       (q_bundle)
  );

  assign pc_value    = q_bundle.pc;
  assign instruction = q_bundle.instruction;
  assign valid       = q_bundle.valid;

endmodule

// File: tb/tb_fd_pipeline_register.sv
// Directed bench for fd_pipeline_register; flush scenario runs only with FD_FLUSH_EN.
module tb_fd_pipeline_register;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_value_next;
  logic [31:0] next_instruction;
  logic        valid_next;
  logic        stall;
`ifdef FD_FLUSH_EN
  logic        flush;
`endif
  logic [31:0] pc_value;
  logic [31:0] instruction;
  logic        valid;

  int errors = 0;
  int checks = 0;

  fd_pipeline_register dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_value_next    (pc_value_next),
    .next_instruction (next_instruction),
    .valid_next       (valid_next),
    .stall            (stall),
`ifdef FD_FLUSH_EN
    .flush            (flush),
`endif
    .pc_value         (pc_value),
    .instruction      (instruction),
    .valid            (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #1;
    checks++;
    if (pc_value !== 32'h0) begin
      errors++; $display("FAIL reset_pc got=%h exp=%h", pc_value, 32'h0);
    end
    checks++;
    if (instruction !== NOP) begin
      errors++; $display("FAIL reset_instr got=%h exp=%h", instruction, NOP);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b exp=0", valid);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    rst_n            = 1'b1;
    next_instruction = 32'hAABBAABB;
    pc_value_next    = 32'h1;
    valid_next       = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (instruction !== 32'hAABBAABB) begin
      errors++; $display("FAIL load_instr got=%h exp=aabbaabb", instruction);
    end
    checks++;
    if (pc_value !== 32'h1) begin
      errors++; $display("FAIL load_pc got=%h exp=00000001", pc_value);
    end
    checks++;
    if (valid !== 1'b1) begin
      errors++; $display("FAIL load_valid got=%b exp=1", valid);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    next_instruction = 32'hCCCCCCCC;
    pc_value_next    = 32'hDD;
    valid_next       = 1'b1;
    #1;
    checks++;
    if (instruction !== 32'hAABBAABB) begin
      errors++; $display("FAIL b2b_hold_instr got=%h exp=aabbaabb", instruction);
    end
    checks++;
    if (pc_value !== 32'h1) begin
      errors++; $display("FAIL b2b_hold_pc got=%h exp=00000001", pc_value);
    end
    @(posedge clk); #1;
    checks++;
    if (instruction !== 32'hCCCCCCCC) begin
      errors++; $display("FAIL b2b_instr got=%h exp=cccccccc", instruction);
    end
    checks++;
    if (pc_value !== 32'hDD) begin
      errors++; $display("FAIL b2b_pc got=%h exp=000000dd", pc_value);
    end
  endtask

  // Stall with changing and unknown inputs, then release with valid_next=0.
  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall            = 1'b1;
      next_instruction = (i == 1) ? 32'hxxxxxxxx : 32'h11111111;
      pc_value_next    = (i == 1) ? 32'hxxxxxxxx : 32'h44;
      valid_next       = (i == 1) ? 1'bx : 1'b0;
      @(posedge clk); #1;
      checks++;
      if (instruction !== 32'hCCCCCCCC) begin
        errors++; $display("FAIL stall_instr[%0d] got=%h exp=cccccccc", i, instruction);
      end
      checks++;
      if (pc_value !== 32'hDD) begin
        errors++; $display("FAIL stall_pc[%0d] got=%h exp=000000dd", i, pc_value);
      end
      checks++;
      if (valid !== 1'b1) begin
        errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, valid);
      end
    end
    @(negedge clk);
    stall = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (instruction !== 32'h11111111) begin
      errors++; $display("FAIL unstall_instr got=%h exp=11111111", instruction);
    end
    checks++;
    if (pc_value !== 32'h44) begin
      errors++; $display("FAIL unstall_pc got=%h exp=00000044", pc_value);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL unstall_valid got=%b exp=0", valid);
    end
  endtask

  task automatic test_full_width();
    @(negedge clk);
    next_instruction = 32'hFFFF0001;
    pc_value_next    = 32'h80000001;
    valid_next       = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (instruction !== 32'hFFFF0001) begin
      errors++; $display("FAIL width_instr got=%h exp=ffff0001", instruction);
    end
    checks++;
    if (pc_value !== 32'h80000001) begin
      errors++; $display("FAIL width_pc got=%h exp=80000001", pc_value);
    end
  endtask

`ifdef FD_FLUSH_EN
  task automatic test_flush();
    @(negedge clk);
    flush            = 1'b1;
    stall            = 1'b1;
    next_instruction = 32'h12345678;
    pc_value_next    = 32'h80;
    valid_next       = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (instruction !== NOP) begin
      errors++; $display("FAIL flush_instr got=%h exp=%h", instruction, NOP);
    end
    checks++;
    if (pc_value !== 32'h80) begin
      errors++; $display("FAIL flush_pc got=%h exp=00000080", pc_value);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL flush_valid got=%b exp=0", valid);
    end
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    @(negedge clk);
    next_instruction = 32'h5A5A5A5A;
    pc_value_next    = 32'h100;
    valid_next       = 1'b1;
    stall            = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b1) begin
      errors++; $display("FAIL premid_valid got=%b exp=1", valid);
    end
    #2;
    stall = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc_value !== 32'h0) begin
      errors++; $display("FAIL midrst_pc got=%h exp=00000000", pc_value);
    end
    checks++;
    if (instruction !== NOP) begin
      errors++; $display("FAIL midrst_instr got=%h exp=%h", instruction, NOP);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid got=%b exp=0", valid);
    end
    @(posedge clk); #1;
    checks++;
    if (instruction !== NOP) begin
      errors++; $display("FAIL rsthold_instr got=%h exp=%h", instruction, NOP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (instruction !== 32'h5A5A5A5A) begin
      errors++; $display("FAIL postrst_instr got=%h exp=5a5a5a5a", instruction);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    pc_value_next    = 32'h0;
    next_instruction = 32'h0;
    valid_next       = 1'b0;
    stall            = 1'b0;
`ifdef FD_FLUSH_EN
    flush            = 1'b0;
`endif
    test_reset();
    test_load();
    test_back_to_back();
    test_stall();
    test_full_width();
`ifdef FD_FLUSH_EN
    test_flush();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
